// File: rtl/round_robin_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding, sizing
// constants and the rotating-priority pick helpers.
package round_robin_mux_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Lowest offset from p wins: scanning backwards lets the nearest requester overwrite.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [SEL_W-1:0]   p);
        logic [SEL_W-1:0] idx;
        rr_pick = p;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = p + SEL_W'(i);
            if (r[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] s);
        sel_to_onehot    = '0;
        sel_to_onehot[s] = 1'b1;
    endfunction

endpackage

// File: rtl/round_robin_mux_arbiter_mux.sv
// Width-parameterised 4:1 payload multiplexer used by the arbiter's data path.
module multiplexer4to1 #(
    parameter int W = 32
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [W-1:0] y
);

    // Route the selected requester payload through unchanged.
    always_comb begin
        y = '0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/round_robin_mux_arbiter.sv
// Four-requester round-robin arbiter with a registered payload output.
// Define ARB_LOCK_EN to add the lock port that holds priority on the current grantee.
module round_robin_mux_arbiter
    import round_robin_mux_arbiter_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [W-1:0] data0,
    input  logic [W-1:0] data1,
    input  logic [W-1:0] data2,
    input  logic [W-1:0] data3,
    input  logic         out_ready,
`ifdef ARB_LOCK_EN
    input  logic [3:0]   lock,
`endif
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [3:0]   gnt,
    output logic [1:0]   sel,
    output logic [3:0]   ack
);

    state_t               state_r;
    logic [SEL_W-1:0]     ptr_r;
    logic [SEL_W-1:0]     sel_r;
    logic [NUM_REQ-1:0]   gnt_r;
    logic                 valid_r;
    logic [W-1:0]         data_r;
    logic [SEL_W-1:0]     pick_s;
    logic [SEL_W-1:0]     ptr_next_s;
    logic [NUM_REQ-1:0]   ack_s;
    logic [W-1:0]         mux_data_s;

    // Next grantee from the rotating priority pointer.
    always_comb begin
        pick_s = rr_pick(req, ptr_r);
    end

    multiplexer4to1 #(.W(W)) u_mux (
        .sel (pick_s),
        .d0  (data0),
        .d1  (data1),
        .d2  (data2),
        .d3  (data3),
        .y   (mux_data_s)
    );

    // Pointer after a handshake; a held lock keeps priority on the current grantee.
    always_comb begin
        ptr_next_s = sel_r + 2'd1;
`ifdef ARB_LOCK_EN
        if (lock[sel_r]) begin
            ptr_next_s = sel_r;
        end else begin
            ptr_next_s = sel_r + 2'd1;
        end
`endif
    end

    // Completion pulse is combinational so it lines up with the accepting edge.
    always_comb begin
        ack_s = '0;
        if ((state_r == BUSY) && out_ready) begin
            ack_s[sel_r] = 1'b1;
        end else begin
            ack_s = '0;
        end
    end

    // Arbitration FSM and registered grant/payload outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ptr_r   <= 2'd0;
            sel_r   <= 2'd0;
            gnt_r   <= 4'b0000;
            valid_r <= 1'b0;
            data_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|req) begin
                        gnt_r   <= sel_to_onehot(pick_s);
                        sel_r   <= pick_s;
                        data_r  <= mux_data_s;
                        valid_r <= 1'b1;
                        state_r <= BUSY;
                    end
                end
                BUSY: begin
                    if (valid_r && out_ready) begin
                        ptr_r   <= ptr_next_s;
                        gnt_r   <= 4'b0000;
                        valid_r <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt_r   <= 4'b0000;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign gnt       = gnt_r;
    assign sel       = sel_r;
    assign ack       = ack_s;

endmodule

// File: tb/tb_round_robin_mux_arbiter.sv
// Self-checking bench: directed vector table, hand sequences and a randomized
// run against a rule-level reference model.
module tb_round_robin_mux_arbiter;

    localparam int W = 32;
    localparam logic [31:0] D0 = 32'h0A0A_0A00;
    localparam logic [31:0] D1 = 32'h1111_1111;
    localparam logic [31:0] D2 = 32'hDEAD_BEEF;
    localparam logic [31:0] D3 = 32'h3333_3333;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [W-1:0] data0, data1, data2, data3;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [3:0]   ack;
`ifdef ARB_LOCK_EN
    logic [3:0]   lock;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    round_robin_mux_arbiter #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .data3     (data3),
        .out_ready (out_ready),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .gnt       (gnt),
        .sel       (sel),
        .ack       (ack)
    );

    typedef struct {
        logic        r;
        logic [3:0]  rq;
        logic        rdy;
        logic        ev;
        logic [3:0]  eg;
        logic [1:0]  es;
        logic [3:0]  ea;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs[25];

    function automatic logic [31:0] dconst(input int i);
        case (i)
            0:       dconst = D0;
            1:       dconst = D1;
            2:       dconst = D2;
            default: dconst = D3;
        endcase
    endfunction

    function automatic logic [31:0] dcur(input int i);
        case (i)
            0:       dcur = data0;
            1:       dcur = data1;
            2:       dcur = data2;
            default: dcur = data3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive, compare at the falling edge, advance past the rising edge.
    task automatic cyc(input string tag, input logic r, input logic [3:0] rq, input logic rdy,
                       input logic ev, input logic [3:0] eg, input logic [1:0] es,
                       input logic [3:0] ea, input logic [31:0] ed);
        rst_n     = r;
        req       = rq;
        out_ready = rdy;
        @(negedge clk);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, " gnt"},       32'(gnt),       32'(eg));
        chk({tag, " sel"},       32'(sel),       32'(es));
        chk({tag, " ack"},       32'(ack),       32'(ea));
        chk({tag, " out_data"},  out_data,       ed);
        @(posedge clk);
        #1;
    endtask

    int          m_ptr;
    int          m_sel;
    bit          m_busy;
    logic [31:0] m_data;
    bit          found;
    logic [3:0]  rq_v;
    logic        rdy_v;
    logic [3:0]  e_gnt;
    logic [3:0]  e_ack;

    initial begin
        rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0;
        data0 = D0; data1 = D1; data2 = D2; data3 = D3;
`ifdef ARB_LOCK_EN
        lock = 4'b0000;
`endif
        // Reset with all requesting, release, single request, then fairness burst.
        vecs[0] = '{1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000, 32'h0};
        vecs[1] = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000, 32'h0};
        vecs[2] = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0001, 2'd0, 4'b0000, D0};
        vecs[3] = '{1'b1, 4'b0000, 1'b1, 1'b1, 4'b0001, 2'd0, 4'b0001, D0};
        vecs[4] = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0000, D0};
        vecs[5] = '{1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0000, D0};
        vecs[6] = '{1'b1, 4'b0000, 1'b1, 1'b1, 4'b0100, 2'd2, 4'b0100, D2};
        vecs[7] = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd2, 4'b0000, D2};
        vecs[8] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0000, 32'h0};
        for (int k = 0; k < 16; k++) begin
            int g;
            int pg;
            g  = (k / 2) % 4;
            pg = ((k - 1) / 2) % 4;
            if (k % 2 == 1)
                vecs[9+k] = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001 << g, 2'(g), 4'b0001 << g, dconst(g)};
            else if (k == 0)
                vecs[9+k] = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0000, 32'h0};
            else
                vecs[9+k] = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'(pg), 4'b0000, dconst(pg)};
        end

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 25; i++) begin
            cyc($sformatf("vec%0d", i), vecs[i].r, vecs[i].rq, vecs[i].rdy,
                vecs[i].ev, vecs[i].eg, vecs[i].es, vecs[i].ea, vecs[i].ed);
        end

        // Backpressure: requester 1 held five cycles while data1 changes and req[3] rises.
        cyc("bp_req", 1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000, 2'd3, 4'b0000, D3);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) data1 = 32'h5555_AAAA;
            cyc("bp_hold", 1'b1, 4'b1010, 1'b0, 1'b1, 4'b0010, 2'd1, 4'b0000, D1);
        end
        cyc("bp_ack",  1'b1, 4'b1000, 1'b1, 1'b1, 4'b0010, 2'd1, 4'b0010, D1);
        cyc("bp_idle", 1'b1, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'd1, 4'b0000, D1);
        cyc("bp_next", 1'b1, 4'b0000, 1'b1, 1'b1, 4'b1000, 2'd3, 4'b1000, D3);
        data1 = D1;

        // Mid-transaction reset: pointer moved to 3 first, so a restart at 0 is observable.
        cyc("mr_a",   1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000, 2'd3, 4'b0000, D3);
        cyc("mr_b",   1'b1, 4'b0000, 1'b1, 1'b1, 4'b0100, 2'd2, 4'b0100, D2);
        cyc("mr_c",   1'b1, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'd2, 4'b0000, D2);
        cyc("mr_d",   1'b1, 4'b0000, 1'b0, 1'b1, 4'b1000, 2'd3, 4'b0000, D3);
        cyc("mr_rst", 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0000, 32'h0);
        cyc("mr_rel", 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000, 32'h0);
        cyc("mr_gnt", 1'b1, 4'b0000, 1'b1, 1'b1, 4'b0001, 2'd0, 4'b0001, D0);

`ifdef ARB_LOCK_EN
        cyc("lk_rst", 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0000, 32'h0);
        lock = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            cyc("lk_idle", 1'b1, 4'b0011, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0000, (i == 0) ? 32'h0 : D0);
            cyc("lk_gnt",  1'b1, 4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 4'b0001, D0);
        end
        cyc("lk_idle", 1'b1, 4'b0011, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0000, D0);
        lock = 4'b0000;
        cyc("lk_unl",  1'b1, 4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 4'b0001, D0);
        cyc("lk_idl2", 1'b1, 4'b0011, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0000, D0);
        cyc("lk_g1",   1'b1, 4'b0011, 1'b1, 1'b1, 4'b0010, 2'd1, 4'b0010, D1);
`endif

        // Randomized run against the rule-level model, starting from reset.
        cyc("rnd_rst", 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000, 32'h0);
        m_ptr = 0; m_sel = 0; m_busy = 1'b0; m_data = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            rq_v  = 4'($urandom_range(0, 15));
            rdy_v = ($urandom_range(0, 3) != 0);
            if (!rq_v[0]) data0 = $urandom;
            if (!rq_v[1]) data1 = $urandom;
            if (!rq_v[2]) data2 = $urandom;
            if (!rq_v[3]) data3 = $urandom;
`ifdef ARB_LOCK_EN
            lock = 4'($urandom_range(0, 15));
`endif
            rst_n = 1'b1; req = rq_v; out_ready = rdy_v;
            @(negedge clk);
            e_gnt = m_busy ? (4'b0001 << m_sel) : 4'b0000;
            e_ack = (m_busy && rdy_v) ? (4'b0001 << m_sel) : 4'b0000;
            chk("rnd out_valid", 32'(out_valid), 32'(m_busy));
            chk("rnd gnt",       32'(gnt),       32'(e_gnt));
            chk("rnd sel",       32'(sel),       32'(m_sel));
            chk("rnd ack",       32'(ack),       32'(e_ack));
            chk("rnd out_data",  out_data,       m_data);
            if (!m_busy) begin
                if (rq_v != 4'b0000) begin
                    found = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        if (!found && rq_v[(m_ptr + k) % 4]) begin
                            m_sel = (m_ptr + k) % 4;
                            found = 1'b1;
                        end
                    end
                    m_data = dcur(m_sel);
                    m_busy = 1'b1;
                end
            end else if (rdy_v) begin
                m_busy = 1'b0;
                m_ptr  = (m_sel + 1) % 4;
`ifdef ARB_LOCK_EN
                if (lock[m_sel]) m_ptr = m_sel;
`endif
            end
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
